trig_seq_ctrl: RTL and testbench

- Master-side trigger sequencer placed after the 64-channel sum/threshold block.
- Takes the single-cycle master trigger pulse and gates it with enable, inhibit, prescale and dead time.
- Numbers each accepted trigger and serialises a 3-word trigger token onto the 16-bit comma/data link toward the channel FPGAs.
- Keeps accepted and lost trigger counters for the control registers.

---
 rtl/trig_seq_ctrl.sv | 177 +++++++++++++++++
 tb/tb_trig_seq_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/trig_seq_ctrl.sv
// Master trigger sequencer: gates trigger requests, numbers accepted triggers
// and serialises a 3-word token (header, number lo, number hi) onto the link.
module trig_seq_ctrl #(
    parameter logic [15:0] CH_COMMA = 16'h00BC,
    parameter logic [15:0] TOK_HDR  = 16'hC000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trig_req,
    input  logic        enable,
    input  logic        inhibit,
    input  logic [15:0] prescale,
    input  logic [15:0] dead_time,
    input  logic        cnt_clr,
    output logic [15:0] tokdata,
    output logic        tokcomma,
    output logic        busy,
    output logic [31:0] trig_cnt,
    output logic [15:0] lost_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_W0,
        S_W1,
        S_W2,
        S_DEAD
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [15:0] r_psc;
    logic [15:0] r_dead;
    logic [31:0] r_snap;
    logic [31:0] r_trig_cnt;
    logic [15:0] r_lost_cnt;
    logic [15:0] r_tokdata;
    logic        r_tokcomma;
    logic        r_busy;

    logic        w_eligible;
    logic        w_accept;
    logic        w_loss;
    logic [15:0] w_psc_next;
    logic [15:0] w_dead_next;
    logic [31:0] w_snap_next;
    logic [31:0] w_trig_next;
    logic [15:0] w_lost_next;
    logic [15:0] w_tokdata_next;
    logic        w_tokcomma_next;
    logic        w_busy_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_psc_next      = r_psc;
        w_dead_next     = r_dead;
        w_snap_next     = r_snap;
        w_trig_next     = r_trig_cnt;
        w_lost_next     = r_lost_cnt;
        w_tokdata_next  = CH_COMMA;
        w_tokcomma_next = 1'b1;
        w_busy_next     = 1'b0;

        w_eligible = trig_req & enable & (r_state == S_IDLE) & ~inhibit;
        // psc may exceed prescale after a prescale change; that still accepts
        w_accept   = w_eligible & (r_psc >= prescale);
        w_loss     = trig_req & enable & ~w_eligible;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = S_W0;
                end
            end
            S_W0:   w_next_state = S_W1;
            S_W1:   w_next_state = S_W2;
            S_W2: begin
                if (dead_time == 16'd0) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_DEAD;
                    w_dead_next  = dead_time;
                end
            end
            S_DEAD: begin
                if (r_dead == 16'd1) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_dead_next = r_dead - 16'd1;
                end
            end
            default: w_next_state = S_IDLE;
        endcase

        if (w_accept) begin
            w_psc_next  = '0;
            w_snap_next = r_trig_cnt;
            w_trig_next = r_trig_cnt + 32'd1;
        end else if (w_eligible) begin
            w_psc_next = r_psc + 16'd1;
        end

        if (w_loss && (r_lost_cnt != 16'hFFFF)) begin
            w_lost_next = r_lost_cnt + 16'd1;
        end

        // Clear overrides counting but a coincident accept still counts once as trigger 0
        if (cnt_clr) begin
            w_psc_next  = '0;
            w_lost_next = '0;
            if (w_accept) begin
                w_snap_next = '0;
                w_trig_next = 32'd1;
            end else begin
                w_trig_next = '0;
            end
        end

        case (w_next_state)
            S_W0: begin
                w_tokdata_next  = TOK_HDR;
                w_tokcomma_next = 1'b0;
            end
            S_W1: begin
                w_tokdata_next  = w_snap_next[15:0];
                w_tokcomma_next = 1'b0;
            end
            S_W2: begin
                w_tokdata_next  = w_snap_next[31:16];
                w_tokcomma_next = 1'b0;
            end
            default: begin
                w_tokdata_next  = CH_COMMA;
                w_tokcomma_next = 1'b1;
            end
        endcase
        w_busy_next = (w_next_state != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_psc      <= '0;
            r_dead     <= '0;
            r_snap     <= '0;
            r_trig_cnt <= '0;
            r_lost_cnt <= '0;
            r_tokdata  <= CH_COMMA;
            r_tokcomma <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_psc      <= w_psc_next;
            r_dead     <= w_dead_next;
            r_snap     <= w_snap_next;
            r_trig_cnt <= w_trig_next;
            r_lost_cnt <= w_lost_next;
            r_tokdata  <= w_tokdata_next;
            r_tokcomma <= w_tokcomma_next;
            r_busy     <= w_busy_next;
        end
    end

    assign tokdata  = r_tokdata;
    assign tokcomma = r_tokcomma;
    assign busy     = r_busy;
    assign trig_cnt = r_trig_cnt;
    assign lost_cnt = r_lost_cnt;

endmodule

// File: tb/tb_trig_seq_ctrl.sv
// Bench for trig_seq_ctrl: directed scenarios plus random traffic checked
// against a queue-of-expected-words reference model.
module tb_trig_seq_ctrl;

    localparam logic [15:0] COMMA = 16'h00BC;
    localparam logic [15:0] HDR   = 16'hC000;

    logic        clk = 1'b0;
    logic        reset;
    logic        trig_req;
    logic        enable;
    logic        inhibit;
    logic [15:0] prescale;
    logic [15:0] dead_time;
    logic        cnt_clr;
    logic [15:0] tokdata;
    logic        tokcomma;
    logic        busy;
    logic [31:0] trig_cnt;
    logic [15:0] lost_cnt;

    trig_seq_ctrl #(.CH_COMMA(COMMA), .TOK_HDR(HDR)) dut (
        .clk      (clk),
        .reset    (reset),
        .trig_req (trig_req),
        .enable   (enable),
        .inhibit  (inhibit),
        .prescale (prescale),
        .dead_time(dead_time),
        .cnt_clr  (cnt_clr),
        .tokdata  (tokdata),
        .tokcomma (tokcomma),
        .busy     (busy),
        .trig_cnt (trig_cnt),
        .lost_cnt (lost_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        busy;
        logic        comma;
        logic        last;
        logic [15:0] data;
    } ent_t;

    ent_t        q[$];
    ent_t        m_exp;
    logic        m_busy;
    logic        m_last;
    logic [31:0] m_trig;
    logic [15:0] m_lost;
    logic [15:0] m_psc;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_exp  = '{busy: 1'b0, comma: 1'b1, last: 1'b0, data: COMMA};
        m_busy = 1'b0;
        m_last = 1'b0;
        m_trig = '0;
        m_lost = '0;
        m_psc  = '0;
    endtask

    // One clock edge of the reference: decide acceptance, then emit the next link word
    task automatic model_edge();
        logic        acc;
        logic [31:0] snap;
        acc = 1'b0;
        if (trig_req && enable && !m_busy && !inhibit) begin
            if (m_psc >= prescale) begin
                acc    = 1'b1;
                snap   = cnt_clr ? 32'd0 : m_trig;
                m_trig = cnt_clr ? 32'd1 : m_trig + 32'd1;
                m_psc  = '0;
                q.push_back('{busy: 1'b1, comma: 1'b0, last: 1'b0, data: HDR});
                q.push_back('{busy: 1'b1, comma: 1'b0, last: 1'b0, data: snap[15:0]});
                q.push_back('{busy: 1'b1, comma: 1'b0, last: 1'b1, data: snap[31:16]});
            end else begin
                m_psc = m_psc + 16'd1;
            end
        end else if (trig_req && enable && m_lost != 16'hFFFF) begin
            m_lost = m_lost + 16'd1;
        end
        if (cnt_clr) begin
            m_lost = '0;
            m_psc  = '0;
            if (!acc) m_trig = '0;
        end
        if (q.size() == 0 && m_last) begin
            for (int i = 0; i < int'(dead_time); i++)
                q.push_back('{busy: 1'b1, comma: 1'b1, last: 1'b0, data: COMMA});
        end
        if (q.size() > 0) m_exp = q.pop_front();
        else m_exp = '{busy: 1'b0, comma: 1'b1, last: 1'b0, data: COMMA};
        m_last = m_exp.last;
        m_busy = m_exp.busy;
    endtask

    task automatic step(input bit do_chk);
        @(posedge clk);
        model_edge();
        #1;
        if (do_chk) begin
            chk("tokdata", {16'd0, tokdata}, {16'd0, m_exp.data});
            chk("tokcomma", {31'd0, tokcomma}, {31'd0, m_exp.comma});
            chk("busy", {31'd0, busy}, {31'd0, m_exp.busy});
            chk("trig_cnt", trig_cnt, m_trig);
            chk("lost_cnt", {16'd0, lost_cnt}, {16'd0, m_lost});
        end
    endtask

    task automatic do_reset();
        trig_req = 1'b0;
        cnt_clr  = 1'b0;
        reset    = 1'b1;
        #1;
        model_reset();
        chk("rst_tokdata", {16'd0, tokdata}, {16'd0, COMMA});
        chk("rst_tokcomma", {31'd0, tokcomma}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_trig_cnt", trig_cnt, 32'd0);
        chk("rst_lost_cnt", {16'd0, lost_cnt}, 32'd0);
        #2;
        reset = 1'b0;
    endtask

    task automatic pulses(input logic [63:0] pat, input int n, input int tail);
        for (int i = 0; i < n; i++) begin
            trig_req = pat[i];
            step(1'b1);
        end
        trig_req = 1'b0;
        for (int i = 0; i < tail; i++) step(1'b1);
    endtask

    initial begin
        enable    = 1'b1;
        inhibit   = 1'b0;
        prescale  = '0;
        dead_time = '0;
        do_reset();

        // single trigger, numbered 0
        pulses(64'h1, 1, 6);
        chk("single_trig_cnt", trig_cnt, 32'd1);

        // pulse during a token is lost, later pulse accepted
        do_reset();
        pulses(64'b1000101, 7, 6);
        chk("overlap_lost", {16'd0, lost_cnt}, 32'd1);

        // continuous requests with dead time
        do_reset();
        dead_time = 16'd5;
        pulses(64'hFFFFF, 20, 15);
        chk("dead_trig_cnt", trig_cnt, 32'd3);
        chk("dead_lost_cnt", {16'd0, lost_cnt}, 32'd17);

        // prescale 3: every 4th eligible request
        do_reset();
        dead_time = 16'd0;
        prescale  = 16'd3;
        for (int i = 0; i < 8; i++) pulses(64'h1, 1, 19);
        chk("psc_trig_cnt", trig_cnt, 32'd2);
        chk("psc_lost_cnt", {16'd0, lost_cnt}, 32'd0);

        // inhibit blocks and counts losses
        do_reset();
        prescale = 16'd0;
        inhibit  = 1'b1;
        pulses(64'b10101, 5, 4);
        inhibit = 1'b0;
        chk("inh_lost_cnt", {16'd0, lost_cnt}, 32'd3);
        chk("inh_trig_cnt", trig_cnt, 32'd0);

        // asynchronous reset during W1 aborts the token
        pulses(64'h1, 1, 1);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("abort_tokdata", {16'd0, tokdata}, {16'd0, COMMA});
        chk("abort_tokcomma", {31'd0, tokcomma}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        #2;
        reset = 1'b0;
        pulses(64'h0, 0, 3);

        // clear coincident with accept numbers the token 0
        pulses(64'h1, 1, 4);
        pulses(64'h1, 1, 4);
        cnt_clr = 1'b1;
        trig_req = 1'b1;
        step(1'b1);
        cnt_clr = 1'b0;
        pulses(64'h0, 0, 4);
        chk("clr_trig_cnt", trig_cnt, 32'd1);

        // lost counter saturation
        inhibit  = 1'b1;
        trig_req = 1'b1;
        for (int i = 0; i < 65540; i++) step(1'b0);
        trig_req = 1'b0;
        inhibit  = 1'b0;
        step(1'b1);
        chk("lost_sat", {16'd0, lost_cnt}, 32'h0000FFFF);

        // random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            trig_req = 1'($urandom_range(0, 1));
            enable   = (($urandom % 10) != 0);
            inhibit  = (($urandom % 8) == 0);
            cnt_clr  = (($urandom % 64) == 0);
            if (($urandom % 50) == 0) prescale  = 16'($urandom_range(0, 3));
            if (($urandom % 40) == 0) dead_time = 16'($urandom_range(0, 4));
            step(1'b1);
        end
        trig_req = 1'b0;
        cnt_clr  = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
